verbus_router: RTL
==================

# verbus_router

Parametrised data-bus router between one Verbus initiator (CPU data bus) and `NUM_TARGETS` Verbus targets (RAM, timer, UART, further peripherals). It decodes the top `SEL_WIDTH` address bits against per-target base codes and latches the selected target for the whole transaction. It answers unmapped accesses and watchdogs stalled targets with a bounded timeout. It also records error status and combines target interrupts under a mask.

## Interface
- `NUM_TARGETS`, 4: number of target channels (1..16).
- `SEL_WIDTH`, 8: number of decoded address MSBs, `m_address[31 -: SEL_WIDTH]`.
- `TARGET_BASES`, {8'h82, 8'h81, 8'h80, 8'h00}: packed `NUM_TARGETS*SEL_WIDTH` codes; target i uses slice `[i*SEL_WIDTH +: SEL_WIDTH]`.
- `TIMEOUT_CYCLES`, 255: stall limit in cycles, 16-bit max; 0 disables the timeout.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `m_valid` in 1, `m_address` in 32, `m_wstrobe` in 4, `m_wdata` in 32: initiator request.
- `m_ready` out 1, `m_rdata` out 32, `m_irq` out 1: initiator response and interrupt.
- `t_valid` out N: per-target request strobe.
- `t_address` out 32, `t_wstrobe` out 4, `t_wdata` out 32: broadcast copies of the `m_*` request fields.
- `t_ready` in N, `t_rdata` in N*32, `t_irq` in N: per-target responses and interrupts.
- `irq_enable` in N: per-target interrupt mask.
- `err_pulse` out 1: one-cycle pulse on each error response.
- `err_kind` out 1: 0 = unmapped, 1 = timeout; reflects the last error.
- `err_address` out 32: address of the last error.
- `err_count` out 16: saturating error counter.

## Operation
- Verbus handshake:
  - The initiator holds `m_valid`, address, strobe and data stable until a cycle with `m_ready`=1.
  - That cycle completes the transfer.
  - `m_rdata` is valid only when `m_ready`=1 and is 0 otherwise.
- Decode: the target is the lowest index i whose code equals `m_address[31 -: SEL_WIDTH]`. A miss is unmapped.
- FSM states: IDLE, BUSY.
- IDLE, `m_valid`=0: all `t_valid`=0, `m_ready`=0.
- IDLE, `m_valid`=1, hit on target i:
  - Combinationally `t_valid[i]`=1, `m_ready`=`t_ready[i]`, `m_rdata`=`t_rdata[i]`.
  - If `t_ready[i]`=1, the transfer completes and the FSM stays in IDLE (zero added latency).
  - Otherwise latch i into `sel_q`, clear `wait_cnt` to 1, and go to BUSY.
- IDLE, `m_valid`=1, miss:
  - Combinationally `m_ready`=1, `m_rdata`=0, no `t_valid`.
  - Error recorded with kind 0.
- BUSY: route through `sel_q` only; decode is ignored.
  - On `t_ready[sel_q]`=1: forward rdata, `m_ready`=1, go to IDLE.
  - Else if `TIMEOUT_CYCLES`≠0 and `wait_cnt`==`TIMEOUT_CYCLES`: `t_valid` forced 0, `m_ready`=1, `m_rdata`=0, error kind 1, go to IDLE.
  - Else `wait_cnt` increments.
  - `m_valid` dropping in BUSY (protocol violation): all `t_valid`=0, return to IDLE, no error.
- Error record, on the completing cycle:
  - Registered: `err_pulse`=1 next cycle; `err_kind`, `err_address`=`m_address` and `err_count`+1 update next cycle.
  - `err_count` saturates at 16'hFFFF.
- Interrupt: `m_irq` = |(`t_irq` & `irq_enable`), combinational.
- `t_address`/`t_wstrobe`/`t_wdata` always mirror the `m_*` fields.

## Timing
- Reset, synchronous: FSM to IDLE, `sel_q`=0, `wait_cnt`=0, `err_pulse`=0, `err_kind`=0, `err_address`=0, `err_count`=0.
- Reset mid-transaction in BUSY: the transaction is abandoned, with no `m_ready` and no error. Combinational outputs follow the IDLE rules from the next cycle.
- Latency:
  - Hit with a ready target: 0 added cycles.
  - Unmapped: `m_ready` in the first valid cycle.
  - Timeout: `m_ready` in cycle `TIMEOUT_CYCLES` counted from the first valid cycle (cycle 0).
- Back-to-back transfers: after any completion, a new `m_valid` in the following cycle is decoded afresh in IDLE.
- Simultaneous `t_ready` and timeout in the same cycle: ready wins, with no error.
- `err_pulse` is high exactly one cycle per error, including back-to-back errors (pulses in consecutive cycles).

## Test plan
- Read at 32'h0000_0010 with RAM target ready same cycle, rdata 32'h1234_5678 → `m_ready`=1 in cycle 0, `m_rdata`=32'h1234_5678, only `t_valid[0]` high, no error.
- Write to 32'h8100_0000 with UART target ready after 3 stall cycles → `t_valid[2]` high for 4 cycles, `m_ready` in cycle 3, FSM back in IDLE.
- Read at 32'h4000_0000 (unmapped) → `m_ready`=1, `m_rdata`=0 in cycle 0; next cycle `err_pulse`=1, `err_kind`=0, `err_address`=32'h4000_0000, `err_count`=1.
- `TIMEOUT_CYCLES`=16, timer target never ready → `m_ready`=1 with rdata 0 in cycle 16, `t_valid[1]`=0 in that cycle, `err_kind`=1. Target becoming ready exactly in cycle 16 → normal completion, `err_count` unchanged.
- Reset asserted in BUSY cycle 5 of a stalled access → no `m_ready`, all status outputs 0 after reset. Then force 65536 unmapped accesses → `err_count` saturates at 16'hFFFF.
- `t_irq`=4'b0110 with `irq_enable`=4'b0100 → `m_irq`=1. With `irq_enable`=4'b1001 → `m_irq`=0.

Source files
------------

// File: rtl/verbus_router.sv
// Verbus data-bus router: decodes the initiator address onto NUM_TARGETS target
// channels, answers unmapped/stalled accesses, records errors and merges interrupts.
module verbus_router #(
    parameter int unsigned NUM_TARGETS    = 4,
    parameter int unsigned SEL_WIDTH      = 8,
    parameter logic [NUM_TARGETS*SEL_WIDTH-1:0] TARGET_BASES = {8'h82, 8'h81, 8'h80, 8'h00},
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m_valid,
    input  logic [31:0]               m_address,
    input  logic [3:0]                m_wstrobe,
    input  logic [31:0]               m_wdata,
    output logic                      m_ready,
    output logic [31:0]               m_rdata,
    output logic                      m_irq,
    output logic [NUM_TARGETS-1:0]    t_valid,
    output logic [31:0]               t_address,
    output logic [3:0]                t_wstrobe,
    output logic [31:0]               t_wdata,
    input  logic [NUM_TARGETS-1:0]    t_ready,
    input  logic [NUM_TARGETS*32-1:0] t_rdata,
    input  logic [NUM_TARGETS-1:0]    t_irq,
    input  logic [NUM_TARGETS-1:0]    irq_enable,
    output logic                      err_pulse,
    output logic                      err_kind,
    output logic [31:0]               err_address,
    output logic [15:0]               err_count
);

    localparam int unsigned IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [15:0]        wait_cnt, wait_d;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [IDX_W-1:0]   route_idx;
    logic               ready_sel;
    logic [31:0]        rdata_sel;
    logic               err_event;
    logic               err_kind_d;

    assign t_address = m_address;
    assign t_wstrobe = m_wstrobe;
    assign t_wdata   = m_wdata;
    assign m_irq     = |(t_irq & irq_enable);

    // Lowest matching index wins when several targets share a code.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
            if (!hit && TARGET_BASES[i*SEL_WIDTH +: SEL_WIDTH] == m_address[31 -: SEL_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign route_idx = (state_q == BUSY) ? sel_q : hit_idx;

    always_comb begin
        ready_sel = 1'b0;
        rdata_sel = '0;
        for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
            if (route_idx == IDX_W'(i)) begin
                ready_sel = t_ready[i];
                rdata_sel = t_rdata[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        wait_d     = wait_cnt;
        t_valid    = '0;
        m_ready    = 1'b0;
        m_rdata    = '0;
        err_event  = 1'b0;
        err_kind_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_valid) begin
                    if (hit) begin
                        t_valid[hit_idx] = 1'b1;
                        m_ready          = ready_sel;
                        if (ready_sel) begin
                            m_rdata = rdata_sel;
                        end else begin
                            state_d = BUSY;
                            sel_d   = hit_idx;
                            wait_d  = 16'd1;
                        end
                    end else begin
                        m_ready   = 1'b1;
                        err_event = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!m_valid) begin
                    state_d = IDLE;
                end else if (ready_sel) begin
                    t_valid[sel_q] = 1'b1;
                    m_ready        = 1'b1;
                    m_rdata        = rdata_sel;
                    state_d        = IDLE;
                end else if (TIMEOUT_CYCLES != 0 && wait_cnt == TIMEOUT_LIM) begin
                    m_ready    = 1'b1;
                    err_event  = 1'b1;
                    err_kind_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    t_valid[sel_q] = 1'b1;
                    wait_d         = wait_cnt + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            wait_cnt    <= '0;
            err_pulse   <= 1'b0;
            err_kind    <= 1'b0;
            err_address <= '0;
            err_count   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wait_cnt  <= wait_d;
            err_pulse <= err_event;
            if (err_event) begin
                err_kind    <= err_kind_d;
                err_address <= m_address;
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end

endmodule
